// File: rtl/pipe_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline: load-use and branch hazards,
// data-memory handshake with watchdog. Optional stall counter under PIPE_CTRL_PERF_EN.
module pipe_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_rs_addr,
  input  logic [4:0]  id_rt_addr,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic [4:0]  ex_rd_addr,
  input  logic        ex_mem_read,
  input  logic        ex_branch_taken,
  input  logic        mem_op,
  input  logic        dmem_ready,
  output logic        pc_en,
  output logic        if_id_en,
  output logic        id_ex_en,
  output logic        ex_mem_en,
  output logic        mem_wb_en,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        mem_wb_bubble,
  output logic        dmem_req,
  output logic        dmem_err,
  output logic [31:0] stall_cycles
);

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT);

  state_t      state, state_nxt;
  logic [15:0] wcnt, wcnt_nxt;
  logic        load_use;
  logic        advance;
  logic        timeout_hit;

  // Register 0 is hardwired, so a load targeting it can never create a dependency.
  assign load_use = ex_mem_read && (ex_rd_addr != 5'd0) &&
                    ((id_uses_rs && (id_rs_addr == ex_rd_addr)) ||
                     (id_uses_rt && (id_rt_addr == ex_rd_addr)));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= RUN;
      wcnt  <= '0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
    end
  end

  // NOTE: every output is given a default first so this block can never infer a latch.
  always_comb begin
    state_nxt     = state;
    wcnt_nxt      = wcnt;
    advance       = 1'b0;
    timeout_hit   = 1'b0;
    pc_en         = 1'b0;
    if_id_en      = 1'b0;
    id_ex_en      = 1'b0;
    ex_mem_en     = 1'b0;
    mem_wb_en     = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    mem_wb_bubble = 1'b0;
    dmem_req      = 1'b0;
    dmem_err      = 1'b0;

    // Outputs are forced low while reset is held so an abandoned request drops at once.
    if (reset) begin
      unique case (state)
        RUN: begin
          dmem_req = mem_op;
          advance  = !mem_op || dmem_ready;
          if (!advance) begin
            state_nxt = MEM_WAIT;
            wcnt_nxt  = 16'd1;
          end
        end
        MEM_WAIT: begin
          dmem_req    = 1'b1;
          timeout_hit = !dmem_ready && (wcnt == TIMEOUT_W);
          advance     = dmem_ready || timeout_hit;
          dmem_err    = timeout_hit;
          if (advance) begin
            state_nxt = RUN;
            wcnt_nxt  = '0;
          end else begin
            wcnt_nxt  = wcnt + 16'd1;
          end
        end
      endcase

      if (advance) begin
        pc_en     = 1'b1;
        if_id_en  = 1'b1;
        id_ex_en  = 1'b1;
        ex_mem_en = 1'b1;
        mem_wb_en = 1'b1;
        // Branch squash wins over load-use: the dependent instruction is discarded anyway.
        if (ex_branch_taken) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end else if (load_use) begin
          pc_en       = 1'b0;
          if_id_en    = 1'b0;
          id_ex_flush = 1'b1;
        end
      end else begin
        mem_wb_en     = 1'b1;
        mem_wb_bubble = 1'b1;
      end
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (!pc_en && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign stall_cycles = stall_cnt;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl (TIMEOUT=4): hazards, memory freeze,
// zero-wait access, watchdog and asynchronous reset during a wait.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  id_rs_addr, id_rt_addr, ex_rd_addr;
  logic        id_uses_rs, id_uses_rt, ex_mem_read, ex_branch_taken;
  logic        mem_op, dmem_ready;
  logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic        if_id_flush, id_ex_flush, mem_wb_bubble, dmem_req, dmem_err;
  logic [31:0] stall_cycles;
  logic [9:0]  outs;

  int n_cmp = 0;
  int n_err = 0;

`ifdef PIPE_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // {pc, if_id, id_ex, ex_mem, mem_wb enables, if_id_flush, id_ex_flush, bubble, req, err}
  localparam logic [9:0] ZERO   = 10'b00000_000_00;
  localparam logic [9:0] ADV    = 10'b11111_000_00;
  localparam logic [9:0] LU     = 10'b00111_010_00;
  localparam logic [9:0] BR     = 10'b11111_110_00;
  localparam logic [9:0] FRZ    = 10'b00001_001_10;
  localparam logic [9:0] REL_BR = 10'b11111_110_10;
  localparam logic [9:0] ZW     = 10'b11111_000_10;
  localparam logic [9:0] TO_ERR = 10'b11111_000_11;

  pipe_ctrl #(.TIMEOUT(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .id_rs_addr      (id_rs_addr),
    .id_rt_addr      (id_rt_addr),
    .id_uses_rs      (id_uses_rs),
    .id_uses_rt      (id_uses_rt),
    .ex_rd_addr      (ex_rd_addr),
    .ex_mem_read     (ex_mem_read),
    .ex_branch_taken (ex_branch_taken),
    .mem_op          (mem_op),
    .dmem_ready      (dmem_ready),
    .pc_en           (pc_en),
    .if_id_en        (if_id_en),
    .id_ex_en        (id_ex_en),
    .ex_mem_en       (ex_mem_en),
    .mem_wb_en       (mem_wb_en),
    .if_id_flush     (if_id_flush),
    .id_ex_flush     (id_ex_flush),
    .mem_wb_bubble   (mem_wb_bubble),
    .dmem_req        (dmem_req),
    .dmem_err        (dmem_err),
    .stall_cycles    (stall_cycles)
  );

  assign outs = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                 if_id_flush, id_ex_flush, mem_wb_bubble, dmem_req, dmem_err};

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    id_rs_addr = 5'd0; id_rt_addr = 5'd0; ex_rd_addr = 5'd0;
    id_uses_rs = 1'b0; id_uses_rt = 1'b0; ex_mem_read = 1'b0;
    ex_branch_taken = 1'b0; mem_op = 1'b0; dmem_ready = 1'b0;
  endtask

  // Request never answered: freeze in RUN, three quiet waits, error on the fourth wait cycle.
  task automatic run_timeout(input string tag);
    tick(); mem_op = 1'b1; dmem_ready = 1'b0; #1;
    check({tag, "_req"}, 32'(outs), 32'(FRZ));
    for (int i = 1; i <= 3; i++) begin
      tick(); #1;
      check({tag, "_wait"}, 32'(outs), 32'(FRZ));
    end
    tick(); #1;
    check({tag, "_err"}, 32'(outs), 32'(TO_ERR));
    tick(); mem_op = 1'b0; #1;
    check({tag, "_run"}, 32'(outs), 32'(ADV));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    clear_inputs();
    reset = 1'b0;
    mem_op = 1'b1;
    ex_branch_taken = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      check("rst_outs", 32'(outs), 32'(ZERO));
      check("rst_stall", stall_cycles, 32'd0);
    end

    tick(); clear_inputs(); reset = 1'b1; #1;
    check("run_idle", 32'(outs), 32'(ADV));

    tick(); ex_mem_read = 1'b1; ex_rd_addr = 5'd5; id_rs_addr = 5'd5; id_uses_rs = 1'b1; #1;
    check("lu_rs", 32'(outs), 32'(LU));
    tick(); clear_inputs(); #1;
    check("lu_cleared", 32'(outs), 32'(ADV));

    tick(); ex_mem_read = 1'b1; ex_rd_addr = 5'd0; id_rs_addr = 5'd0; id_uses_rs = 1'b1; #1;
    check("r0_nohaz", 32'(outs), 32'(ADV));

    tick(); clear_inputs(); ex_mem_read = 1'b1; ex_rd_addr = 5'd7; id_rt_addr = 5'd7; id_uses_rt = 1'b1; #1;
    check("lu_rt", 32'(outs), 32'(LU));
    tick(); id_uses_rt = 1'b0; id_rs_addr = 5'd7; #1;
    check("rt_unused", 32'(outs), 32'(ADV));
    tick(); id_uses_rs = 1'b1; ex_mem_read = 1'b0; #1;
    check("no_load", 32'(outs), 32'(ADV));

    tick(); clear_inputs(); ex_mem_read = 1'b1; ex_rd_addr = 5'd5; id_rs_addr = 5'd5;
    id_uses_rs = 1'b1; ex_branch_taken = 1'b1; #1;
    check("br_over_lu", 32'(outs), 32'(BR));

    tick(); clear_inputs(); reset = 1'b0; #1;
    check("perf_clr_outs", 32'(outs), 32'(ZERO));
    check("perf_clr", stall_cycles, 32'd0);
    tick(); reset = 1'b1; #1;
    check("rerun", 32'(outs), 32'(ADV));

    // Ready three cycles after the request, with a taken branch pending in EX throughout.
    tick(); mem_op = 1'b1; ex_branch_taken = 1'b1; #1;
    check("mem_req", 32'(outs), 32'(FRZ));
    for (int i = 1; i <= 2; i++) begin
      tick(); #1;
      check("mem_wait", 32'(outs), 32'(FRZ));
    end
    tick(); dmem_ready = 1'b1; #1;
    check("mem_release", 32'(outs), 32'(REL_BR));
    tick(); clear_inputs(); #1;
    check("mem_back_run", 32'(outs), 32'(ADV));
    check("mem_stall_cnt", stall_cycles, PERF ? 32'd3 : 32'd0);

    tick(); mem_op = 1'b1; dmem_ready = 1'b1; #1;
    check("zero_wait", 32'(outs), 32'(ZW));
    tick(); clear_inputs(); #1;
    check("zw_stall_cnt", stall_cycles, PERF ? 32'd3 : 32'd0);

    run_timeout("to");
    check("to_stall_cnt", stall_cycles, PERF ? 32'd7 : 32'd0);

    // Reset asserted in the second wait cycle must drop the request immediately.
    tick(); mem_op = 1'b1; #1;
    check("ar_req", 32'(outs), 32'(FRZ));
    tick(); #1;
    check("ar_wait1", 32'(outs), 32'(FRZ));
    tick(); #1;
    check("ar_wait2", 32'(outs), 32'(FRZ));
    reset = 1'b0; #1;
    check("ar_async", 32'(outs), 32'(ZERO));
    tick(); #1;
    check("ar_held", 32'(outs), 32'(ZERO));
    tick(); reset = 1'b1; mem_op = 1'b0; #1;
    check("ar_post_run", 32'(outs), 32'(ADV));
    check("ar_stall_cnt", stall_cycles, 32'd0);

    run_timeout("ar_to");
    check("ar_to_stall_cnt", stall_cycles, PERF ? 32'd4 : 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
